// File: rtl/pipo_wr_arbiter.sv
// pipo_wr_arbiter
//   Round-robin write arbiter that owns the load enables of a small bank of
//   parallel-in/parallel-out registers. One requester is granted at a time.
//   The granted requester's data is loaded into its addressed register on the
//   edge that follows the grant, provided it still holds its request.
//   All register contents are presented in parallel on reg_q.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req          per-requester level request, held until granted
//   wdata        per-requester write data, slice i = wdata[i*WIDTH +: WIDTH]
//   waddr        per-requester target register, slice i = waddr[i*AW +: AW]
//   gnt          registered one-hot grant
//   busy         high while a grant is outstanding
//   reg_q        parallel bank contents, slice k = register k
//   last_id      requester that completed the most recent write
//   wr_count     completed writes, saturating at 255
//   abort_count  withdrawn grants, saturating at 255
module pipo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  localparam int AW   = $clog2(NREG),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [NREQ*AW-1:0]    waddr,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NREG*WIDTH-1:0] reg_q,
  output logic [IW-1:0]         last_id,
  output logic [7:0]            wr_count,
  output logic [7:0]            abort_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GNT  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic [IW-1:0]        win_q, win_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        last_id_q, last_id_d;
  logic [7:0]           wr_count_q, wr_count_d;
  logic [7:0]           abort_count_q, abort_count_d;
  logic [WIDTH-1:0]     bank_q [NREG];
  logic [WIDTH-1:0]     bank_d [NREG];

  logic [AW-1:0]        sel_addr_s;
  logic [WIDTH-1:0]     sel_data_s;

  // First requesting index found when scanning upward from p, wrapping.
  // Scanning from the far end downward lets the nearest hit overwrite.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
    int idx;
    rr_pick = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx     = (int'(p) + k) % NREQ;
      rr_pick = r[idx] ? IW'(idx) : rr_pick;
    end
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [IW-1:0] w);
    one_hot    = '0;
    one_hot[w] = 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Address and data of the currently held winner.
  always_comb begin
    sel_addr_s = waddr[win_q*AW +: AW];
    sel_data_s = wdata[win_q*WIDTH +: WIDTH];
  end

  // Next-state, grant, pointer, counter and bank-load logic.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    busy_d        = busy_q;
    win_d         = win_q;
    ptr_d         = ptr_q;
    last_id_d     = last_id_q;
    wr_count_d    = wr_count_q;
    abort_count_d = abort_count_q;
    bank_d        = bank_q;

    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          win_d   = rr_pick(req, ptr_q);
          gnt_d   = one_hot(win_d);
          busy_d  = 1'b1;
          state_d = ST_GNT;
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_GNT: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        // Only the winner's own request matters here; others are ignored.
        if (req[win_q]) begin
          bank_d[sel_addr_s] = sel_data_s;
          ptr_d      = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
          last_id_d  = win_q;
          wr_count_d = sat_inc(wr_count_q);
        end else begin
          abort_count_d = sat_inc(abort_count_q);
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      busy_q        <= 1'b0;
      win_q         <= '0;
      ptr_q         <= '0;
      last_id_q     <= '0;
      wr_count_q    <= 8'd0;
      abort_count_q <= 8'd0;
      for (int k = 0; k < NREG; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      win_q         <= win_d;
      ptr_q         <= ptr_d;
      last_id_q     <= last_id_d;
      wr_count_q    <= wr_count_d;
      abort_count_q <= abort_count_d;
      for (int k = 0; k < NREG; k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  // Flatten the bank onto the parallel output; pure wiring from flops.
  always_comb begin
    reg_q = '0;
    for (int k = 0; k < NREG; k++) begin
      reg_q[k*WIDTH +: WIDTH] = bank_q[k];
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign last_id     = last_id_q;
  assign wr_count    = wr_count_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_pipo_wr_arbiter.sv
// Directed testbench for pipo_wr_arbiter (NREQ=4, WIDTH=4, NREG=4).
module tb_pipo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [7:0]  waddr;
  logic [3:0]  gnt;
  logic        busy;
  logic [15:0] reg_q;
  logic [1:0]  last_id;
  logic [7:0]  wr_count;
  logic [7:0]  abort_count;

  int n_checks;
  int n_fail;

  pipo_wr_arbiter #(.NREQ(4), .WIDTH(4), .NREG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .wdata       (wdata),
    .waddr       (waddr),
    .gnt         (gnt),
    .busy        (busy),
    .reg_q       (reg_q),
    .last_id     (last_id),
    .wr_count    (wr_count),
    .abort_count (abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // ---------------- reset with garbage inputs ----------------
    rst_n = 1'b0;
    req   = 4'b1011;
    wdata = 16'hDEAD;
    waddr = 8'hC5;
    step();
    step();
    check("rst_gnt",   32'(gnt),         32'h0);
    check("rst_busy",  32'(busy),        32'h0);
    check("rst_reg_q", 32'(reg_q),       32'h0);
    check("rst_wrcnt", 32'(wr_count),    32'h0);
    check("rst_abcnt", 32'(abort_count), 32'h0);
    check("rst_last",  32'(last_id),     32'h0);

    // ---------------- round-robin fairness (ptr=0) ----------------
    // req i writes value 5+i to address 3-i
    req   = 4'b0000;
    rst_n = 1'b1;
    step();
    req   = 4'b1111;
    wdata = 16'h8765;
    waddr = 8'h1B;
    step(); check("rr_g0", 32'(gnt), 32'h1);
    check("rr_busy", 32'(busy), 32'h1);
    step(); check("rr_c0", 32'(gnt), 32'h0);
    step(); check("rr_g1", 32'(gnt), 32'h2);
    step();
    step(); check("rr_g2", 32'(gnt), 32'h4);
    step();
    step(); check("rr_g3", 32'(gnt), 32'h8);
    step();
    check("rr_reg_q", 32'(reg_q),    32'h5678);
    check("rr_wrcnt", 32'(wr_count), 32'd4);
    check("rr_last",  32'(last_id),  32'd3);
    step(); check("rr_g0_again", 32'(gnt), 32'h1);
    req = 4'b0001;  // others dropping during GNT must not matter
    step();
    req = 4'b0000;
    check("rr_reg_q2", 32'(reg_q),    32'h5678);  // requester 0 rewrote 5 to reg3
    check("rr_wrcnt2", 32'(wr_count), 32'd5);
    check("rr_last2",  32'(last_id),  32'd0);

    // ---------------- clear, then single write ----------------
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("clr_reg_q", 32'(reg_q),    32'h0);
    check("clr_wrcnt", 32'(wr_count), 32'h0);
    req   = 4'b0100;
    wdata = 16'h0A00;
    waddr = 8'h30;
    step();
    check("sw_gnt",  32'(gnt),  32'h4);
    check("sw_busy", 32'(busy), 32'h1);
    check("sw_noearly", 32'(reg_q), 32'h0);
    step();
    req = 4'b0000;
    check("sw_reg_q", 32'(reg_q),    32'hA000);
    check("sw_gnt0",  32'(gnt),      32'h0);
    check("sw_busy0", 32'(busy),     32'h0);
    check("sw_last",  32'(last_id),  32'd2);
    check("sw_wrcnt", 32'(wr_count), 32'd1);

    // ---------------- wrap-around from ptr=3 ----------------
    req   = 4'b0011;
    wdata = 16'h0021;   // slice0=1, slice1=2
    waddr = 8'h04;      // slice0=0, slice1=1
    step(); check("wrap_g0", 32'(gnt), 32'h1);
    step();
    check("wrap_reg_q", 32'(reg_q),   32'hA001);
    check("wrap_last",  32'(last_id), 32'd0);
    step(); check("wrap_g1", 32'(gnt), 32'h2);

    // ---------------- withdrawal of requester 1 ----------------
    req = 4'b0000;
    step();
    check("wd_gnt",   32'(gnt),         32'h0);
    check("wd_busy",  32'(busy),        32'h0);
    check("wd_abcnt", 32'(abort_count), 32'd1);
    check("wd_reg_q", 32'(reg_q),       32'hA001);
    check("wd_wrcnt", 32'(wr_count),    32'd2);
    check("wd_last",  32'(last_id),     32'd0);
    // ptr still 1, so requester 1 beats 2 and 0
    req = 4'b0111;
    step(); check("wd_regrant", 32'(gnt), 32'h2);
    step();
    req = 4'b0000;
    check("wd_reg_q2", 32'(reg_q),    32'hA021);
    check("wd_wrcnt2", 32'(wr_count), 32'd3);
    check("wd_last2",  32'(last_id),  32'd1);

    // ---------------- reset mid-grant ----------------
    req   = 4'b0100;
    wdata = 16'h0F00;
    waddr = 8'h30;
    step(); check("mr_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b0000;
    check("mr_gnt",   32'(gnt),         32'h0);
    check("mr_busy0", 32'(busy),        32'h0);
    check("mr_reg_q", 32'(reg_q),       32'h0);
    check("mr_wrcnt", 32'(wr_count),    32'h0);
    check("mr_abcnt", 32'(abort_count), 32'h0);
    check("mr_last",  32'(last_id),     32'h0);
    step();
    check("mr_nowrite", 32'(reg_q), 32'h0);

    // ---------------- write-counter saturation ----------------
    req   = 4'b0001;
    wdata = 16'h0003;
    waddr = 8'h00;
    for (int i = 0; i < 508; i++) step();
    check("sat_254", 32'(wr_count), 32'd254);
    step(); step();
    check("sat_255", 32'(wr_count), 32'd255);
    for (int i = 0; i < 10; i++) step();
    req = 4'b0000;
    check("sat_hold", 32'(wr_count), 32'd255);
    check("sat_reg_q", 32'(reg_q),   32'h0003);

    // ---------------- abort-counter saturation ----------------
    for (int i = 0; i < 260; i++) begin
      req = 4'b0010;
      step();
      req = 4'b0000;
      step();
    end
    check("ab_sat",   32'(abort_count), 32'd255);
    check("ab_wrcnt", 32'(wr_count),    32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
